// File: rtl/sdram_client_responder_if.sv
// ============================================================================
// sdram_client_responder_if - client, arbitration and memory-port signals of
// the SDRAM client responder. Rev 1.0
// ============================================================================
`default_nettype none

interface sdram_client_responder_if #(
    parameter int ADDR_W = 22,
    parameter int DATA_W = 32
);
    // Client command side
    logic [1:0]        i_Command;
    logic [ADDR_W-1:0] i_Data_Address;
    logic [DATA_W-1:0] i_Data_Write;
    logic [DATA_W-1:0] o_Data_Read;
    logic              o_Data_Read_Valid;
    logic              o_Data_Write_Done;
    logic              o_SDRAM_Requested;
    logic              i_SDRAM_Yield;
    // Priority requester
    logic              i_Priority_Req;
    logic              o_Priority_Grant;
    // Single-word memory port
    logic              o_Mem_Req;
    logic              o_Mem_We;
    logic [ADDR_W-1:0] o_Mem_Addr;
    logic [DATA_W-1:0] o_Mem_Wdata;
    logic              i_Mem_Ack;
    logic [DATA_W-1:0] i_Mem_Rdata;
    logic              o_Timeout;

    modport slave (
        input  i_Command, i_Data_Address, i_Data_Write, i_SDRAM_Yield,
               i_Priority_Req, i_Mem_Ack, i_Mem_Rdata,
        output o_Data_Read, o_Data_Read_Valid, o_Data_Write_Done,
               o_SDRAM_Requested, o_Priority_Grant, o_Mem_Req, o_Mem_We,
               o_Mem_Addr, o_Mem_Wdata, o_Timeout
    );

    modport master (
        output i_Command, i_Data_Address, i_Data_Write, i_SDRAM_Yield,
               i_Priority_Req, i_Mem_Ack, i_Mem_Rdata,
        input  o_Data_Read, o_Data_Read_Valid, o_Data_Write_Done,
               o_SDRAM_Requested, o_Priority_Grant, o_Mem_Req, o_Mem_We,
               o_Mem_Addr, o_Mem_Wdata, o_Timeout
    );
endinterface

`default_nettype wire

// File: rtl/sdram_client_responder.sv
// ============================================================================
// sdram_client_responder - serves one client word by word over a single-word
// memory port, arbitrated against a priority requester via request/yield.
// Optional memory-ack watchdog: define RESP_TIMEOUT_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module sdram_client_responder #(
    parameter int ADDR_W         = 22,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  wire logic               i_Clk,
    input  wire logic               i_Rst_n,
    sdram_client_responder_if.slave bus
);

    localparam logic [1:0] c_CMD_READ  = 2'b01;
    localparam logic [1:0] c_CMD_WRITE = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_MEM_WAIT = 3'd1,
        S_COMPLETE = 3'd2,
        S_GAP      = 3'd3,
        S_GRANTED  = 3'd4
    } state_t;

    state_t            state_q,     state_d;
    logic              mem_req_q,   mem_req_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] rd_data_q,   rd_data_d;
    logic              rd_valid_q,  rd_valid_d;
    logic              wr_done_q,   wr_done_d;
    logic              requested_q, requested_d;
    logic              grant_q,     grant_d;

`ifdef RESP_TIMEOUT_EN
    localparam int c_TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [c_TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic               timeout_q, timeout_d;
`endif

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q     <= S_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            wr_done_q   <= 1'b0;
            requested_q <= 1'b0;
            grant_q     <= 1'b0;
`ifdef RESP_TIMEOUT_EN
            tmo_cnt_q   <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            wr_done_q   <= wr_done_d;
            requested_q <= requested_d;
            grant_q     <= grant_d;
`ifdef RESP_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        wr_done_d   = 1'b0;
        requested_d = bus.i_Priority_Req;
        grant_d     = grant_q;
`ifdef RESP_TIMEOUT_EN
        tmo_cnt_d   = '0;
        timeout_d   = timeout_q;
`endif

        case (state_q)
            S_IDLE: begin
                // Yield wins over a pending client command.
                if (bus.i_Priority_Req && bus.i_SDRAM_Yield) begin
                    grant_d = 1'b1;
                    state_d = S_GRANTED;
                end else if (bus.i_Command == c_CMD_READ || bus.i_Command == c_CMD_WRITE) begin
                    mem_addr_d  = bus.i_Data_Address;
                    mem_wdata_d = bus.i_Data_Write;
                    mem_we_d    = (bus.i_Command == c_CMD_WRITE);
                    mem_req_d   = 1'b1;
                    state_d     = S_MEM_WAIT;
                end
            end

            S_MEM_WAIT: begin
                if (bus.i_Mem_Ack) begin
                    mem_req_d = 1'b0;
                    if (!mem_we_q) begin
                        rd_data_d = bus.i_Mem_Rdata;
                    end
                    state_d = S_COMPLETE;
                end
`ifdef RESP_TIMEOUT_EN
                else if (tmo_cnt_q == c_TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    // Give up on the memory but still close the client handshake.
                    mem_req_d = 1'b0;
                    timeout_d = 1'b1;
                    if (!mem_we_q) begin
                        rd_data_d = DATA_W'(32'hDEADBEEF);
                    end
                    state_d = S_COMPLETE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + c_TMO_W'(1);
                end
`endif
            end

            S_COMPLETE: begin
                rd_valid_d = !mem_we_q;
                wr_done_d  = mem_we_q;
                state_d    = S_GAP;
            end

            S_GAP: begin
                state_d = S_IDLE;
            end

            S_GRANTED: begin
                if (!bus.i_Priority_Req) begin
                    grant_d = 1'b0;
                    state_d = S_IDLE;
                end
            end

            default: begin
                mem_req_d = 1'b0;
                grant_d   = 1'b0;
                state_d   = S_IDLE;
            end
        endcase
    end

    assign bus.o_Data_Read       = rd_data_q;
    assign bus.o_Data_Read_Valid = rd_valid_q;
    assign bus.o_Data_Write_Done = wr_done_q;
    assign bus.o_SDRAM_Requested = requested_q;
    assign bus.o_Priority_Grant  = grant_q;
    assign bus.o_Mem_Req         = mem_req_q;
    assign bus.o_Mem_We          = mem_we_q;
    assign bus.o_Mem_Addr        = mem_addr_q;
    assign bus.o_Mem_Wdata       = mem_wdata_q;

`ifdef RESP_TIMEOUT_EN
    assign bus.o_Timeout = timeout_q;
`else
    // Without the watchdog the limit has no effect; the flag is a constant tie-off.
    if (TIMEOUT_CYCLES > 0) begin : g_no_watchdog
        assign bus.o_Timeout = 1'b0;
    end else begin : g_no_watchdog_zero_limit
        assign bus.o_Timeout = 1'b0;
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_sdram_client_responder.sv
// Directed bench for sdram_client_responder: scoreboard of expected client
// results plus a latency-programmable single-word memory model.
`default_nettype none

module tb_sdram_client_responder;

    localparam int ADDR_W = 22;
    localparam int DATA_W = 32;
    localparam int TMO    = 64;
`ifdef RESP_TIMEOUT_EN
    localparam int HOLD_CYC = 20;
`else
    localparam int HOLD_CYC = 80;
`endif

    typedef struct {
        bit                rd;
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] addr;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   cyc;
    exp_t sb[$];

    // Memory model state
    int                mem_lat;
    bit                mem_en;
    int                mcnt;
    bit                stable_err;
    logic [ADDR_W-1:0] snap_addr;
    logic [DATA_W-1:0] snap_wdata;
    logic              snap_we;
    logic [ADDR_W-1:0] ack_addr;
    logic              ack_we;
    logic [DATA_W-1:0] ack_wdata;

    sdram_client_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sdram_client_responder #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .i_Clk  (clk),
        .i_Rst_n(rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DATA_W-1:0] rd_model(input logic [ADDR_W-1:0] a);
        if (a == 22'h000010) return 32'h12345678;
        return {10'h2A5, a};
    endfunction

    function automatic logic [DATA_W-1:0] wr_pat(input logic [ADDR_W-1:0] a);
        return {10'h1B7, a} ^ 32'h5A5A5A5A;
    endfunction

    // Memory: acks mem_lat cycles after the request rises, checks port stability.
    always @(negedge clk) begin
        if (!rst_n) begin
            bus.i_Mem_Ack   = 1'b0;
            bus.i_Mem_Rdata = '0;
            mcnt            = 0;
        end else if (bus.i_Mem_Ack) begin
            bus.i_Mem_Ack = 1'b0;
            mcnt          = 0;
        end else if (bus.o_Mem_Req && mem_en) begin
            if (mcnt == 0) begin
                snap_addr  = bus.o_Mem_Addr;
                snap_wdata = bus.o_Mem_Wdata;
                snap_we    = bus.o_Mem_We;
            end else if (bus.o_Mem_Addr !== snap_addr || bus.o_Mem_Wdata !== snap_wdata ||
                         bus.o_Mem_We !== snap_we) begin
                stable_err = 1'b1;
            end
            mcnt = mcnt + 1;
            if (mcnt >= mem_lat) begin
                bus.i_Mem_Ack   = 1'b1;
                bus.i_Mem_Rdata = bus.o_Mem_We ? '0 : rd_model(bus.o_Mem_Addr);
                ack_addr        = bus.o_Mem_Addr;
                ack_we          = bus.o_Mem_We;
                ack_wdata       = bus.o_Mem_Wdata;
            end
        end else begin
            mcnt = 0;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_pulse(input int budget, output bit got, output bit is_rd);
        got   = 1'b0;
        is_rd = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(posedge clk);
            #1;
            if (bus.o_Data_Read_Valid || bus.o_Data_Write_Done) begin
                got   = 1'b1;
                is_rd = bus.o_Data_Read_Valid;
                return;
            end
        end
    endtask

    task automatic count_pulses(input int n, output int pulses, output int reqs);
        pulses = 0;
        reqs   = 0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            if (bus.o_Data_Read_Valid || bus.o_Data_Write_Done) pulses++;
            if (bus.o_Mem_Req) reqs++;
        end
    endtask

    function automatic exp_t mk_exp(input logic [1:0] cmd, input logic [ADDR_W-1:0] a);
        exp_t e;
        e.rd   = (cmd == 2'b01);
        e.data = e.rd ? rd_model(a) : wr_pat(a);
        e.addr = a;
        return e;
    endfunction

    // Client burst: holds the command, advances the address after each pulse.
    task automatic run_burst(input logic [1:0] cmd, input logic [ADDR_W-1:0] base,
                             input int n, input int lat, input int prio_at);
        bit   got;
        bit   is_rd;
        int   t0;
        int   last;
        exp_t e;
        logic [ADDR_W-1:0] a;
        mem_lat = lat;
        a       = base;
        @(negedge clk);
        bus.i_Command        = cmd;
        bus.i_Data_Address   = a;
        bus.i_Data_Write     = wr_pat(a);
        sb.push_back(mk_exp(cmd, a));
        t0   = cyc;
        last = cyc;
        for (int i = 0; i < n; i++) begin
            wait_pulse(40, got, is_rd);
            check("pulse_seen", 64'(got), 64'd1);
            if (!got) begin
                bus.i_Command = 2'b00;
                sb.delete();
                return;
            end
            e = sb.pop_front();
            check("pulse_kind", 64'(is_rd), 64'(e.rd));
            check("mem_addr", 64'(ack_addr), 64'(e.addr));
            check("mem_we", 64'(ack_we), 64'(!e.rd));
            if (e.rd) check("read_data", 64'(bus.o_Data_Read), 64'(e.data));
            else      check("mem_wdata", 64'(ack_wdata), 64'(e.data));
            if (i == 0) check("first_latency", 64'(cyc - t0), 64'(lat + 2));
            else        check("word_spacing", 64'(cyc - last), 64'(lat + 3));
            last = cyc;
            @(negedge clk);
            if (i == prio_at) bus.i_Priority_Req = 1'b1;
            if (i < n - 1) begin
                a                  = a + 1'b1;
                bus.i_Data_Address = a;
                bus.i_Data_Write   = wr_pat(a);
                sb.push_back(mk_exp(cmd, a));
            end else begin
                bus.i_Command = 2'b00;
            end
            if (i == prio_at) begin
                @(posedge clk);
                #1;
                check("requested_rise", 64'(bus.o_SDRAM_Requested), 64'd1);
                check("no_grant_wo_yield", 64'(bus.o_Priority_Grant), 64'd0);
            end
        end
    endtask

    initial begin
        int  pulses;
        int  reqs;
        bit  nz;
        bit  got;
        bit  is_rd;
        int  t0;
        total = 0;
        bad   = 0;
        cyc   = 0;
        mem_lat    = 1;
        mem_en     = 1'b1;
        stable_err = 1'b0;
        rst_n                 = 1'b0;
        bus.i_Command         = 2'b00;
        bus.i_Data_Address    = '0;
        bus.i_Data_Write      = '0;
        bus.i_SDRAM_Yield     = 1'b0;
        bus.i_Priority_Req    = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state: everything quiet for 20 cycles
        nz = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (bus.o_Mem_Req || bus.o_Mem_We || bus.o_Mem_Addr != 0 || bus.o_Mem_Wdata != 0 ||
                bus.o_Data_Read != 0 || bus.o_Data_Read_Valid || bus.o_Data_Write_Done ||
                bus.o_SDRAM_Requested || bus.o_Priority_Grant) nz = 1'b1;
        end
        check("reset_outputs_zero", 64'(nz), 64'd0);
        check("reset_timeout", 64'(bus.o_Timeout), 64'd0);

        // Single read, ack one cycle after request
        run_burst(2'b01, 22'h000010, 1, 1, -1);

        // 4-word write burst, ack latency 2
        run_burst(2'b10, 22'h020000, 4, 2, -1);
        count_pulses(6, pulses, reqs);
        check("no_extra_pulse", 64'(pulses), 64'd0);

        // 8-word read burst with priority request raised after word 3
        run_burst(2'b01, 22'h001000, 8, 1, 2);
        count_pulses(4, pulses, reqs);
        check("grant_waits_yield", 64'(bus.o_Priority_Grant), 64'd0);
        check("idle_no_req", 64'(reqs), 64'd0);
        @(negedge clk);
        bus.i_SDRAM_Yield = 1'b1;
        @(posedge clk);
        #1;
        check("grant_after_yield", 64'(bus.o_Priority_Grant), 64'd1);
        @(negedge clk);
        bus.i_Command      = 2'b01;
        bus.i_Data_Address = 22'h000200;
        count_pulses(3, pulses, reqs);
        check("granted_ignores_cmd", 64'(reqs + pulses), 64'd0);
        check("grant_held", 64'(bus.o_Priority_Grant), 64'd1);
        @(negedge clk);
        bus.i_Command      = 2'b00;
        bus.i_Priority_Req = 1'b0;
        @(posedge clk);
        #1;
        check("grant_cleared", 64'(bus.o_Priority_Grant), 64'd0);
        check("requested_cleared", 64'(bus.o_SDRAM_Requested), 64'd0);
        @(negedge clk);
        bus.i_SDRAM_Yield = 1'b0;
        run_burst(2'b01, 22'h000123, 1, 1, -1);

        // Priority request falls in the same cycle the yield rises
        @(negedge clk);
        bus.i_Priority_Req = 1'b1;
        @(posedge clk);
        #1;
        check("requested_simul", 64'(bus.o_SDRAM_Requested), 64'd1);
        @(negedge clk);
        bus.i_Priority_Req = 1'b0;
        bus.i_SDRAM_Yield  = 1'b1;
        nz = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            if (bus.o_Priority_Grant) nz = 1'b1;
        end
        check("simul_no_grant", 64'(nz), 64'd0);
        @(negedge clk);
        bus.i_SDRAM_Yield = 1'b0;

`ifdef RESP_TIMEOUT_EN
        // Watchdog: no ack on a read
        mem_en = 1'b0;
        @(negedge clk);
        bus.i_Command      = 2'b01;
        bus.i_Data_Address = 22'h000055;
        @(posedge clk);
        #1;
        @(negedge clk);
        bus.i_Command = 2'b00;
        t0 = cyc;
        for (int k = 0; k < TMO + 20; k++) begin
            @(posedge clk);
            #1;
            if (!bus.o_Mem_Req) break;
        end
        check("timeout_cycles", 64'(cyc - t0 + 1), 64'(TMO));
        wait_pulse(10, got, is_rd);
        check("timeout_pulse", 64'({got, is_rd}), 64'b11);
        check("timeout_data", 64'(bus.o_Data_Read), 64'h00000000DEADBEEF);
        check("timeout_flag", 64'(bus.o_Timeout), 64'd1);
        mem_en = 1'b1;
        run_burst(2'b01, 22'h000056, 1, 1, -1);
        check("timeout_sticky", 64'(bus.o_Timeout), 64'd1);
`endif

        // Reset during MEM_WAIT aborts the word
        mem_en = 1'b0;
        @(negedge clk);
        bus.i_Command      = 2'b01;
        bus.i_Data_Address = 22'h3FFFFF;
        @(negedge clk);
        bus.i_Command = 2'b00;
        count_pulses(HOLD_CYC, pulses, reqs);
        check("wait_no_pulse", 64'(pulses), 64'd0);
        check("wait_req_held", 64'(reqs), 64'(HOLD_CYC));
`ifndef RESP_TIMEOUT_EN
        check("no_watchdog", 64'(bus.o_Timeout), 64'd0);
`endif
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_req", 64'(bus.o_Mem_Req), 64'd0);
        check("async_reset_timeout", 64'(bus.o_Timeout), 64'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        mem_en = 1'b1;
        count_pulses(6, pulses, reqs);
        check("post_reset_quiet", 64'(pulses + reqs), 64'd0);
        run_burst(2'b01, 22'h000010, 1, 1, -1);

        check("mem_port_stable", 64'(stable_err), 64'd0);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

endmodule

`default_nettype wire
